// File: rtl/seq_detect_param_if.sv
// Serial detector bus: input bit stream with enable/rearm, detector outputs back.
interface seq_detect_param_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             X;
  logic             rearm;
  logic             Z;
  logic             locked;
  logic             lock_val;
  logic [CNT_W-1:0] match_count;

  modport master (output en, X, rearm, input Z, locked, lock_val, match_count);
  modport slave  (input en, X, rearm, output Z, locked, lock_val, match_count);
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with saturating match counter.
// Define SEQDET_LOCK_EN to build the run-length lockout (run counters, lock flag/value).
module seq_detect_param #(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b101,
  parameter bit               OVERLAP = 1'b1,
  parameter int               RUN_LEN = 3,
  parameter int               CNT_W   = 8
) (
  input logic               clk,
  input logic               reset,
  seq_detect_param_if.slave bus
);

  if (PAT_W < 2 || RUN_LEN < 2) begin : g_param_chk
    $error("seq_detect_param: PAT_W and RUN_LEN must be at least 2");
  end

  localparam int             FW   = $clog2(PAT_W + 1);
  localparam logic [FW-1:0]  FULL = FW'(PAT_W);

  logic [PAT_W-1:0] hist_q, hist_d, hist_nx;
  logic [FW-1:0]    fill_q, fill_d, fill_nx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             z_q, z_d;
  logic             hit;

`ifdef SEQDET_LOCK_EN
  localparam int            RW   = $clog2(RUN_LEN + 1);
  localparam logic [RW-1:0] RMAX = RW'(RUN_LEN);

  logic [RW-1:0] ones_q, ones_d, zeros_q, zeros_d;
  logic          lock_q, lock_d, lv_q, lv_d;
`endif

  // Match is judged on the history as it will be after this bit is shifted in.
  assign hist_nx = {hist_q[PAT_W-2:0], bus.X};
  assign fill_nx = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
  assign hit     = (hist_nx == PATTERN) && (fill_nx == FULL);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    z_d    = 1'b0;
`ifdef SEQDET_LOCK_EN
    ones_d  = ones_q;
    zeros_d = zeros_q;
    lock_d  = lock_q;
    lv_d    = lv_q;
`endif
    if (bus.rearm) begin
      hist_d = '0;
      fill_d = '0;
`ifdef SEQDET_LOCK_EN
      ones_d  = '0;
      zeros_d = '0;
      lock_d  = 1'b0;
      lv_d    = 1'b0;
`endif
`ifdef SEQDET_LOCK_EN
    end else if (lock_q) begin
      z_d = lv_q;
`endif
    end else if (bus.en) begin
      hist_d = hist_nx;
      fill_d = (hit && !OVERLAP) ? '0 : fill_nx;
      if (hit) begin
        z_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
`ifdef SEQDET_LOCK_EN
      if (bus.X) begin
        ones_d  = (ones_q == RMAX) ? ones_q : ones_q + 1'b1;
        zeros_d = '0;
      end else begin
        zeros_d = (zeros_q == RMAX) ? zeros_q : zeros_q + 1'b1;
        ones_d  = '0;
      end
      // Lock overrides the match pulse, but the match above is still counted.
      if (ones_d == RMAX || zeros_d == RMAX) begin
        lock_d = 1'b1;
        lv_d   = bus.X;
        z_d    = bus.X;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      z_q    <= 1'b0;
`ifdef SEQDET_LOCK_EN
      ones_q  <= '0;
      zeros_q <= '0;
      lock_q  <= 1'b0;
      lv_q    <= 1'b0;
`endif
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      z_q    <= z_d;
`ifdef SEQDET_LOCK_EN
      ones_q  <= ones_d;
      zeros_q <= zeros_d;
      lock_q  <= lock_d;
      lv_q    <= lv_d;
`endif
    end
  end

  assign bus.Z           = z_q;
  assign bus.match_count = cnt_q;
`ifdef SEQDET_LOCK_EN
  assign bus.locked   = lock_q;
  assign bus.lock_val = lv_q;
`else
  assign bus.locked   = 1'b0;
  assign bus.lock_val = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench: default, non-overlapping and 2-bit-counter detectors share one stimulus stream.
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_detect_param_if #(.CNT_W(8)) ia ();
  seq_detect_param_if #(.CNT_W(8)) ib ();
  seq_detect_param_if #(.CNT_W(2)) ic ();

  seq_detect_param u_a (.clk(clk), .reset(reset), .bus(ia));
  seq_detect_param #(.OVERLAP(1'b0)) u_b (.clk(clk), .reset(reset), .bus(ib));
  seq_detect_param #(.CNT_W(2)) u_c (.clk(clk), .reset(reset), .bus(ic));

  // Expected values for the lock build (z/lk/lv/cnt) and the plain build (nz/ncnt).
  typedef struct {
    logic       rst, en, x, rm;
    logic       z, lk, lv;
    logic [7:0] cnt;
    logic       nz;
    logic [7:0] ncnt;
  } vec_t;

  vec_t tv[$];
  int total = 0;
  int bad   = 0;

  task automatic addv(input logic rst, en, x, rm, z, lk, lv, input int cnt,
                      input logic nz, input int ncnt);
    vec_t v;
    v.rst = rst; v.en = en; v.x = x; v.rm = rm;
    v.z = z; v.lk = lk; v.lv = lv; v.cnt = 8'(cnt);
    v.nz = nz; v.ncnt = 8'(ncnt);
    tv.push_back(v);
  endtask

  task automatic drive(input logic r, e, x, rm);
    reset = r;
    ia.en = e; ia.X = x; ia.rearm = rm;
    ib.en = e; ib.X = x; ib.rearm = rm;
    ic.en = e; ic.X = x; ic.rearm = rm;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    logic       ez, elk, elv;
    logic [7:0] ecnt;
    int         m;

    reset = 1'b1;
    ia.en = 0; ia.X = 0; ia.rearm = 0;
    ib.en = 0; ib.X = 0; ib.rearm = 0;
    ic.en = 0; ic.X = 0; ic.rearm = 0;

    //   rst en x rm | z lk lv cnt | nz ncnt
    addv(1, 0, 0, 0,   0, 0, 0, 0,   0, 0);
    addv(0, 1, 1, 0,   0, 0, 0, 0,   0, 0);
    addv(0, 1, 0, 0,   0, 0, 0, 0,   0, 0);
    addv(0, 1, 1, 0,   1, 0, 0, 1,   1, 1);
    addv(0, 1, 0, 0,   0, 0, 0, 1,   0, 1);
    addv(0, 1, 1, 0,   1, 0, 0, 2,   1, 2);
    addv(0, 0, 0, 0,   0, 0, 0, 2,   0, 2);
    addv(0, 1, 0, 0,   0, 0, 0, 2,   0, 2);
    addv(0, 1, 0, 0,   0, 0, 0, 2,   0, 2);
    addv(0, 1, 0, 0,   0, 1, 0, 2,   0, 2);
    addv(0, 1, 1, 0,   0, 1, 0, 2,   0, 2);
    addv(0, 1, 0, 0,   0, 1, 0, 2,   0, 2);
    addv(0, 1, 1, 0,   0, 1, 0, 2,   1, 3);
    addv(0, 1, 1, 1,   0, 0, 0, 2,   0, 3);
    addv(0, 1, 0, 0,   0, 0, 0, 2,   0, 3);
    addv(0, 1, 1, 0,   0, 0, 0, 2,   0, 3);
    addv(0, 1, 1, 0,   0, 0, 0, 2,   0, 3);
    addv(0, 1, 1, 0,   1, 1, 1, 2,   0, 3);
    addv(0, 1, 0, 0,   1, 1, 1, 2,   0, 3);
    addv(0, 0, 0, 0,   1, 1, 1, 2,   0, 3);
    addv(0, 1, 0, 1,   0, 0, 0, 2,   0, 3);
    addv(0, 1, 1, 0,   0, 0, 0, 2,   0, 3);
    addv(0, 0, 0, 0,   0, 0, 0, 2,   0, 3);
    addv(0, 0, 0, 0,   0, 0, 0, 2,   0, 3);
    addv(0, 0, 0, 0,   0, 0, 0, 2,   0, 3);
    addv(0, 1, 0, 0,   0, 0, 0, 2,   0, 3);
    addv(0, 1, 1, 0,   1, 0, 0, 3,   1, 4);
    addv(0, 0, 0, 0,   0, 0, 0, 3,   0, 4);
    addv(0, 1, 1, 0,   0, 0, 0, 3,   0, 4);
    addv(0, 1, 1, 0,   1, 1, 1, 3,   0, 4);
    addv(1, 1, 1, 0,   0, 0, 0, 0,   0, 0);
    addv(0, 1, 1, 0,   0, 0, 0, 0,   0, 0);
    addv(0, 1, 0, 0,   0, 0, 0, 0,   0, 0);
    addv(0, 1, 1, 0,   1, 0, 0, 1,   1, 1);

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rst, tv[i].en, tv[i].x, tv[i].rm);
`ifdef SEQDET_LOCK_EN
      ez = tv[i].z; elk = tv[i].lk; elv = tv[i].lv; ecnt = tv[i].cnt;
`else
      ez = tv[i].nz; elk = 1'b0; elv = 1'b0; ecnt = tv[i].ncnt;
`endif
      chk($sformatf("A.Z row%0d", i), 32'(ia.Z), 32'(ez));
      chk($sformatf("A.locked row%0d", i), 32'(ia.locked), 32'(elk));
      chk($sformatf("A.lock_val row%0d", i), 32'(ia.lock_val), 32'(elv));
      chk($sformatf("A.count row%0d", i), 32'(ia.match_count), 32'(ecnt));
      chk($sformatf("C.count row%0d", i), 32'(ic.match_count), (ecnt > 3) ? 32'd3 : 32'(ecnt));
      chk($sformatf("C.locked row%0d", i), 32'(ic.locked), 32'(elk));
      if (i == 3) chk("B.Z first match", 32'(ib.Z), 32'd1);
      if (i == 5) begin
        chk("B.Z no overlap", 32'(ib.Z), 32'd0);
        chk("B.count no overlap", 32'(ib.match_count), 32'd1);
      end
    end

    // Alternating stream 1,0,1,... (11 bits): five overlapping matches, no runs.
    drive(1, 0, 0, 0);
    m = 0;
    for (int k = 0; k < 11; k++) begin
      drive(0, 1, (k % 2 == 0) ? 1'b1 : 1'b0, 0);
      if (k >= 2 && k % 2 == 0) m++;
      chk($sformatf("C.Z bit%0d", k), 32'(ic.Z), (k >= 2 && k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("C.count bit%0d", k), 32'(ic.match_count), (m > 3) ? 32'd3 : 32'(m));
      chk($sformatf("C.locked bit%0d", k), 32'(ic.locked), 32'd0);
    end
    chk("A.count alt stream", 32'(ia.match_count), 32'd5);
    chk("B.count alt stream", 32'(ib.match_count), 32'd3);

    // Match pulse must be exactly one cycle once the stream goes idle.
    drive(0, 0, 0, 0);
    chk("A.Z after idle", 32'(ia.Z), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial pattern detector with run-length lockout, successor to the fixed 3-bit "101" detector used in the lab FSM series. It samples one serial bit per enabled clock and pulses `Z` for every occurrence of a compile-time pattern of any width, with overlapping or non-overlapping matching. It locks its output after a configurable run of identical bits and counts matches. The block sits between a serial bit source and downstream control or display logic.

## Interface
- `PAT_W`, 3: pattern width in bits, at least 2.
- `PATTERN`, 3'b101: pattern to detect; MSB is the oldest bit.
- `OVERLAP`, 1: 1 = overlapping matches allowed; 0 = history cleared after each match.
- `RUN_LEN`, 3: number of consecutive identical bits that triggers lock, at least 2.
- `CNT_W`, 8: width of the match counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `en` in 1: `X` is sampled on an edge only when `en`=1.
- `X` in 1: serial input bit.
- `rearm` in 1: single-cycle pulse that releases lock.
- `Z` out 1: detector output, registered.
- `locked` out 1: lock active.
- `lock_val` out 1: value `Z` is held at while locked.
- `match_count` out CNT_W: number of matches, saturating.

## Operation
- State: history shift register `hist[PAT_W-1:0]`, fill counter 0..PAT_W, ones/zeros run counters saturating at RUN_LEN, lock flag, lock value, match counter.
- Accepted bit: an edge with `en`=1, `locked`=0, `rearm`=0, `reset`=0.
  - `hist` <= {hist[PAT_W-2:0], X}.
  - The fill counter increments, saturating at PAT_W.
- Match: the new `hist` equals PATTERN and the new fill count equals PAT_W. On a match:
  - `Z` <= 1 for one cycle.
  - `match_count` increments and saturates at 2^CNT_W-1.
  - When OVERLAP=0, the fill counter is cleared to 0.
- `Z` <= 0 on any edge that is not a match and not locked, including edges with `en`=0.
- Run tracking: an accepted 1 increments the ones run and clears the zeros run, and vice versa. Runs count from reset or rearm, independent of the pattern.
- Lock: when an accepted bit makes either run reach RUN_LEN:
  - `locked` <= 1.
  - `lock_val` <= the run's bit value.
  - `Z` <= that bit value.
- While locked:
  - `Z` holds `lock_val`.
  - `X` and `en` are ignored.
  - `hist`, fill, runs and `match_count` are frozen.
- Simultaneous pattern completion and lock (e.g. PATTERN=111): the match is counted, and lock then determines `Z`.
- `rearm`=1 clears `locked`, `lock_val`, `Z`, `hist`, fill and runs, and retains `match_count`. A bit presented in the same cycle is discarded.
- `reset` has priority over everything and clears all registers, including `match_count`.

## Timing
- Reset values: `Z`=0, `locked`=0, `lock_val`=0, `match_count`=0.
- Latency: `Z`, `locked`, `lock_val` and `match_count` update on the edge that samples the completing bit and are visible the following cycle. This is one clock of latency, Moore style.
- A match `Z` pulse lasts exactly one cycle, even if `en` drops immediately afterwards.
- Gaps where `en`=0 do not disturb history or runs. Bits separated by gaps still form patterns and runs.
- Reset asserted mid-lock clears the lock on that edge, and detection resumes at the next accepted bit.

## Configuration
- `SEQDET_LOCK_EN` defined: run counters and lock logic are present, as described above.
- `SEQDET_LOCK_EN` undefined:
  - No run counters are built and RUN_LEN is ignored.
  - `locked` and `lock_val` are tied to 0.
  - `Z` is a pure match pulse.
  - `rearm` only clears `hist` and fill.

## Test plan
All scenarios use the default parameters with the macro defined unless stated otherwise; `en`=1 unless stated otherwise.
- Stream 1,0,1,0,1 -> `Z` pulses the cycle after bits 3 and 5; `match_count`=2; `locked`=0.
- OVERLAP=0, stream 1,0,1,0,1 -> a single `Z` pulse after bit 3; `match_count`=1.
- Stream 1,0,0,0 then 1,0,1 -> after bit 4, `locked`=1, `lock_val`=0 and `Z`=0 held; later bits are ignored; `match_count`=0.
- Stream 0,1,1,1 -> `locked`=1, `lock_val`=1, `Z`=1 held. Then `rearm` pulse -> next cycle `locked`=0, `Z`=0. Then 1,0,1 -> one `Z` pulse; `match_count`=1.
- Stream 1, then `en`=0 for 3 cycles with `X`=0, then 0,1 -> `Z` pulses after the final bit, with no lock from the gated zeros. A `reset` during a later lock -> all outputs 0 the next cycle.
- CNT_W=2, with the macro undefined: stream 1,0,1,0,1,0,1,0,1,0,1 (5 matches) -> `match_count` saturates at 3; `locked` stays 0 throughout.
